// File: rtl/float_div_pkg.sv
// Shared widths, exponent bias and FSM state encoding for the sequential FP32 divider.
package float_div_pkg;

    localparam int FP32_EXP_W    = 8;
    localparam int FP32_MANT_W   = 23;
    localparam int FP32_EXP_BIAS = 127;
    localparam int QUOT_W        = 26;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } div_state_t;

endpackage

// File: rtl/float_div_round.sv
// Combinational normalise / round / exponent / range-flag stage for the divider quotient.
// Round-to-nearest-even is built when FLOAT_DIV_RNE_EN is defined, otherwise the quotient is truncated.
module float_div_round
    import float_div_pkg::*;
(
    input  logic                  i_sign,
    input  logic [FP32_EXP_W-1:0] i_exp_a,
    input  logic [FP32_EXP_W-1:0] i_exp_b,
    input  logic [QUOT_W-1:0]     i_quot,
    input  logic                  i_rem_nz,
    output logic [31:0]           o_result,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    logic [FP32_MANT_W-1:0] w_mant;
    logic [FP32_MANT_W:0]   w_mant_sum;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_adj;
    logic                   w_round_up;
    logic                   w_carry;
    logic signed [9:0]      w_exp;

    always_comb begin
        w_mant   = '0;
        w_guard  = 1'b0;
        w_sticky = 1'b0;
        w_adj    = 1'b0;
        // q[25] set means the mantissa ratio was >= 1; otherwise shift one place and drop the exponent.
        if (i_quot[QUOT_W-1]) begin
            w_mant   = i_quot[24:2];
            w_guard  = i_quot[1];
            w_sticky = i_quot[0] | i_rem_nz;
            w_adj    = 1'b0;
        end else begin
            w_mant   = i_quot[23:1];
            w_guard  = i_quot[0];
            w_sticky = i_rem_nz;
            w_adj    = 1'b1;
        end
    end

`ifdef FLOAT_DIV_RNE_EN
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
`else
    logic w_unused_trunc;
    assign w_unused_trunc = w_guard ^ w_sticky;
    assign w_round_up     = 1'b0;
`endif

    assign w_mant_sum = {1'b0, w_mant} + {{FP32_MANT_W{1'b0}}, w_round_up};
    assign w_carry    = w_mant_sum[FP32_MANT_W];

    assign w_exp = $signed({2'b00, i_exp_a}) - $signed({2'b00, i_exp_b})
                 + $signed(10'(FP32_EXP_BIAS))
                 - $signed({9'd0, w_adj}) + $signed({9'd0, w_carry});

    always_comb begin
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        o_result    = {i_sign, w_exp[7:0], w_mant_sum[FP32_MANT_W-1:0]};
        if (w_exp >= 10'sd255) begin
            o_overflow = 1'b1;
            o_result   = {i_sign, 8'hFF, 23'd0};
        end else if (w_exp <= 10'sd0) begin
            o_underflow = 1'b1;
            o_result    = {i_sign, 31'd0};
        end
    end

endmodule

// File: rtl/float_divider_seq.sv
// Sequential IEEE-754 single divider: restoring division, one quotient bit per clock.
// Rounding mode selected by FLOAT_DIV_RNE_EN (nearest-even when defined, truncate otherwise).
module float_divider_seq
    import float_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in_0,
    input  logic [31:0] data_in_1,
    input  logic        data_in_valid,
    output logic        data_in_ready,
    output logic [31:0] data_out_0,
    output logic        data_out_valid,
    input  logic        data_out_ready,
    output logic        exception,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    div_state_t             r_state;
    logic                   r_sign;
    logic [FP32_EXP_W-1:0]  r_ea;
    logic [FP32_EXP_W-1:0]  r_eb;
    logic [24:0]            r_rem;
    logic [23:0]            r_divisor;
    logic [QUOT_W-1:0]      r_quot;
    logic [4:0]             r_cnt;
    logic [31:0]            r_data_out;
    logic                   r_valid;
    logic                   r_exception;
    logic                   r_overflow;
    logic                   r_underflow;
    logic                   r_div_by_zero;

    logic        w_sign;
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_a_special;
    logic        w_b_special;
    logic        w_ge;
    logic [23:0] w_rem_sub;
    logic [31:0] w_round_result;
    logic        w_round_ovf;
    logic        w_round_unf;

    assign w_sign      = data_in_0[31] ^ data_in_1[31];
    assign w_a_zero    = (data_in_0[30:23] == 8'd0);
    assign w_b_zero    = (data_in_1[30:23] == 8'd0);
    assign w_a_special = (data_in_0[30:23] == 8'hFF);
    assign w_b_special = (data_in_1[30:23] == 8'hFF);

    // Partial remainder never reaches 2*divisor, so after a conditional subtract it fits 24 bits.
    assign w_ge      = (r_rem >= {1'b0, r_divisor});
    assign w_rem_sub = w_ge ? 24'(r_rem - {1'b0, r_divisor}) : r_rem[23:0];

    float_div_round u_round (
        .i_sign      (r_sign),
        .i_exp_a     (r_ea),
        .i_exp_b     (r_eb),
        .i_quot      (r_quot),
        .i_rem_nz    (|r_rem),
        .o_result    (w_round_result),
        .o_overflow  (w_round_ovf),
        .o_underflow (w_round_unf)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_sign        <= 1'b0;
            r_ea          <= '0;
            r_eb          <= '0;
            r_rem         <= '0;
            r_divisor     <= '0;
            r_quot        <= '0;
            r_cnt         <= '0;
            r_data_out    <= '0;
            r_valid       <= 1'b0;
            r_exception   <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (data_in_valid) begin
                        r_sign    <= w_sign;
                        r_ea      <= data_in_0[30:23];
                        r_eb      <= data_in_1[30:23];
                        r_rem     <= {2'b01, data_in_0[22:0]};
                        r_divisor <= {1'b1, data_in_1[22:0]};
                        r_quot    <= '0;
                        r_cnt     <= '0;
                        if (w_a_special || w_b_special || (w_a_zero && w_b_zero)) begin
                            r_data_out  <= 32'd0;
                            r_exception <= 1'b1;
                            r_valid     <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_b_zero) begin
                            r_data_out    <= {w_sign, 8'hFF, 23'd0};
                            r_div_by_zero <= 1'b1;
                            r_valid       <= 1'b1;
                            r_state       <= DONE;
                        end else if (w_a_zero) begin
                            r_data_out <= {w_sign, 31'd0};
                            r_valid    <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_state <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    r_quot <= {r_quot[QUOT_W-2:0], w_ge};
                    r_rem  <= {w_rem_sub, 1'b0};
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == 5'(QUOT_W - 1)) begin
                        r_state <= NORM;
                    end
                end
                NORM: begin
                    r_data_out  <= w_round_result;
                    r_overflow  <= w_round_ovf;
                    r_underflow <= w_round_unf;
                    r_valid     <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (data_out_ready) begin
                        r_valid       <= 1'b0;
                        r_exception   <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_underflow   <= 1'b0;
                        r_div_by_zero <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_in_ready  = (r_state == IDLE);
    assign data_out_0     = r_data_out;
    assign data_out_valid = r_valid;
    assign exception      = r_exception;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;
    assign div_by_zero    = r_div_by_zero;

endmodule

// File: tb/tb_float_divider_seq.sv
// Directed self-checking bench for float_divider_seq; expected values are hand-computed constants.
module tb_float_divider_seq;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in_0;
    logic [31:0] data_in_1;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [31:0] data_out_0;
    logic        data_out_valid;
    logic        data_out_ready;
    logic        exception;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    int n_cmp;
    int n_bad;

    float_divider_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in_0      (data_in_0),
        .data_in_1      (data_in_1),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out_0     (data_out_0),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .exception      (exception),
        .overflow       (overflow),
        .underflow      (underflow),
        .div_by_zero    (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags packed as {exception, overflow, underflow, div_by_zero}.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [3:0] flags,
                         output int lat, output bit tmo);
        int w;
        tmo   = 1'b0;
        res   = 'x;
        flags = 'x;
        lat   = 0;
        @(negedge clk);
        data_in_0     = a;
        data_in_1     = b;
        data_in_valid = 1'b1;
        w = 0;
        while (!data_in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!data_in_ready) begin
            tmo = 1'b1;
            data_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 data_in_valid = 1'b0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (data_out_valid) break;
        end
        if (!data_out_valid) begin
            tmo = 1'b1;
            return;
        end
        res   = data_out_0;
        flags = {exception, overflow, underflow, div_by_zero};
        $display("op %h / %h -> %h flags=%b latency=%0d", a, b, res, flags, lat);
    endtask

    task automatic release_out();
        @(negedge clk);
        data_out_ready = 1'b1;
        @(posedge clk);
        #1 data_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        data_in_valid  = 1'b0;
        data_in_0      = '0;
        data_in_1      = '0;
        data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({data_in_ready, data_out_valid, data_out_0, exception, overflow, underflow, div_by_zero} !== {1'b1, 1'b0, 32'd0, 4'b0000}) begin
            n_bad++;
            $display("FAIL reset_state: got ready=%b valid=%b out=%h flags=%b, want ready=1 valid=0 out=00000000 flags=0000",
                     data_in_ready, data_out_valid, data_out_0, {exception, overflow, underflow, div_by_zero});
        end
    endtask

    task automatic test_normal();
        logic [31:0] r; logic [3:0] f; int lat; bit tmo;
        do_op(32'h40C00000, 32'h40000000, r, f, lat, tmo);
        n_cmp++;
        if (tmo || r !== 32'h40400000 || f !== 4'b0000) begin
            n_bad++;
            $display("FAIL div_6_2: got %h flags=%b tmo=%0d, want 40400000 flags=0000", r, f, tmo);
        end
        n_cmp++;
        if (lat !== 28) begin
            n_bad++;
            $display("FAIL div_6_2_latency: got %0d, want 28", lat);
        end
        release_out();
    endtask

    task automatic test_rounding();
        logic [31:0] r; logic [3:0] f; int lat; bit tmo; logic [31:0] exp_r;
`ifdef FLOAT_DIV_RNE_EN
        exp_r = 32'h3EAAAAAB;
`else
        exp_r = 32'h3EAAAAAA;
`endif
        do_op(32'h3F800000, 32'h40400000, r, f, lat, tmo);
        n_cmp++;
        if (tmo || r !== exp_r || f !== 4'b0000) begin
            n_bad++;
            $display("FAIL div_1_3: got %h flags=%b tmo=%0d, want %h flags=0000", r, f, tmo, exp_r);
        end
        release_out();
    endtask

    task automatic test_specials();
        logic [31:0] va [6]; logic [31:0] vb [6]; logic [31:0] vr [6]; logic [3:0] vf [6];
        logic [31:0] r; logic [3:0] f; int lat; bit tmo;
        va[0] = 32'h3F800000; vb[0] = 32'h00000000; vr[0] = 32'h7F800000; vf[0] = 4'b0001;
        va[1] = 32'h7F800000; vb[1] = 32'h3F800000; vr[1] = 32'h00000000; vf[1] = 4'b1000;
        va[2] = 32'h00000000; vb[2] = 32'h00000000; vr[2] = 32'h00000000; vf[2] = 4'b1000;
        va[3] = 32'hBF800000; vb[3] = 32'h00000000; vr[3] = 32'hFF800000; vf[3] = 4'b0001;
        va[4] = 32'h00000000; vb[4] = 32'hC0000000; vr[4] = 32'h80000000; vf[4] = 4'b0000;
        va[5] = 32'h00400000; vb[5] = 32'h3F800000; vr[5] = 32'h00000000; vf[5] = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], r, f, lat, tmo);
            n_cmp++;
            if (tmo || r !== vr[i] || f !== vf[i] || lat !== 1) begin
                n_bad++;
                $display("FAIL special_%0d: got %h flags=%b lat=%0d tmo=%0d, want %h flags=%b lat=1",
                         i, r, f, lat, tmo, vr[i], vf[i]);
            end
            release_out();
        end
    endtask

    task automatic test_range();
        logic [31:0] r; logic [3:0] f; int lat; bit tmo;
        do_op(32'h7F000000, 32'h3E800000, r, f, lat, tmo);
        n_cmp++;
        if (tmo || r !== 32'h7F800000 || f !== 4'b0100) begin
            n_bad++;
            $display("FAIL overflow: got %h flags=%b tmo=%0d, want 7f800000 flags=0100", r, f, tmo);
        end
        release_out();
        do_op(32'h00800000, 32'h40000000, r, f, lat, tmo);
        n_cmp++;
        if (tmo || r !== 32'h00000000 || f !== 4'b0010) begin
            n_bad++;
            $display("FAIL underflow: got %h flags=%b tmo=%0d, want 00000000 flags=0010", r, f, tmo);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic [3:0] f; int lat; bit tmo;
        do_op(32'h40C00000, 32'h40000000, r, f, lat, tmo);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({data_out_valid, data_in_ready, data_out_0, exception, overflow, underflow, div_by_zero} !== {2'b10, 32'h40400000, 4'b0000}) begin
                n_bad++;
                $display("FAIL hold_%0d: got valid=%b ready=%b out=%h flags=%b, want valid=1 ready=0 out=40400000 flags=0000",
                         i, data_out_valid, data_in_ready, data_out_0, {exception, overflow, underflow, div_by_zero});
            end
        end
        release_out();
        n_cmp++;
        if ({data_out_valid, data_in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL hold_release: got valid=%b ready=%b, want valid=0 ready=1", data_out_valid, data_in_ready);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r; logic [3:0] f; int lat; bit tmo; bit seen;
        @(negedge clk);
        data_in_0     = 32'h40C00000;
        data_in_1     = 32'h40000000;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1 data_in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++;
        if ({data_in_ready, data_out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL abort_state: got ready=%b valid=%b, want ready=1 valid=0", data_in_ready, data_out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_output: got data_out_valid seen=%0d, want 0", seen);
        end
        do_op(32'h40C00000, 32'h40000000, r, f, lat, tmo);
        n_cmp++;
        if (tmo || r !== 32'h40400000 || f !== 4'b0000 || lat !== 28) begin
            n_bad++;
            $display("FAIL after_abort: got %h flags=%b lat=%0d tmo=%0d, want 40400000 flags=0000 lat=28", r, f, lat, tmo);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [3]; logic [31:0] vb [3]; logic [31:0] vr [3];
        logic [31:0] r; logic [3:0] f; int lat; bit tmo;
        va[0] = 32'h3F800000; vb[0] = 32'h3F800000; vr[0] = 32'h3F800000;
        va[1] = 32'hC0C00000; vb[1] = 32'h40000000; vr[1] = 32'hC0400000;
        va[2] = 32'h41000000; vb[2] = 32'hBF000000; vr[2] = 32'hC1800000;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], r, f, lat, tmo);
            n_cmp++;
            if (tmo || r !== vr[i] || f !== 4'b0000 || lat !== 28) begin
                n_bad++;
                $display("FAIL b2b_%0d: got %h flags=%b lat=%0d tmo=%0d, want %h flags=0000 lat=28",
                         i, r, f, lat, tmo, vr[i]);
            end
            release_out();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_normal();
        test_rounding();
        test_specials();
        test_range();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/float_divider_seq.md
FLOAT_DIVIDER_SEQ -- requirements
Module: float_divider_seq

Interface
REQ-001 SHALL have clk  input  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have rst_n  input  1  synchronous, active-low reset.
REQ-003 SHALL have data_in_0  input  32  IEEE-754 single dividend (a).
REQ-004 SHALL have data_in_1  input  32  IEEE-754 single divisor (b).
REQ-005 SHALL have data_in_valid  input  1 and data_in_ready  output  1  input handshake.
REQ-006 SHALL have data_out_0  output  32  quotient a/b.
REQ-007 SHALL have data_out_valid  output  1 and data_out_ready  input  1  output handshake.
REQ-008 SHALL have exception, overflow, underflow, div_by_zero  output  1 each  status flags, meaningful only while data_out_valid=1.

Function
REQ-009 SHALL implement FSM states IDLE, DIVIDE, NORM, DONE.
REQ-010 SHALL assert data_in_ready only in IDLE; a transfer occurs when data_in_valid & data_in_ready, and operands are registered in that cycle.
REQ-011 SHALL compute sign = a[31]^b[31] for every result.
REQ-012 SHALL flush-to-zero inputs: an exponent field of 0 means operand is zero regardless of mantissa.
REQ-013 SHALL classify specials on accept and go IDLE->DONE (data_out_valid on next cycle, latency 1). Priority: exponent 255 in either operand, or both zero -> exception=1, result 0x00000000; b zero -> div_by_zero=1, result {sign,8'hFF,23'd0}; a zero -> result {sign,31'd0}.
REQ-014 Otherwise SHALL go IDLE->DIVIDE, run restoring division of {1,ma} by {1,mb} (24-bit), one quotient bit per cycle, 26 cycles producing q[25:0] plus remainder, then NORM for 1 cycle, then DONE (data_out_valid 28 cycles after accept).
REQ-015 NORM SHALL select: if q[25] mant=q[24:2], guard=q[1], sticky=q[0]|(rem!=0), adj=0; else mant=q[23:1], guard=q[0], sticky=(rem!=0), adj=1.
REQ-016 Exponent SHALL be computed as 10-bit signed: ea - eb + 127 - adj (+1 if rounding carries out of mant, mant becomes 0).
REQ-017 Exponent >= 255 SHALL give overflow=1, result {sign,8'hFF,23'd0}; exponent <= 0 SHALL give underflow=1, result {sign,31'd0}.
REQ-018 In DONE, data_out_0 and all flags SHALL stay stable until data_out_ready=1; on that handshake FSM returns to IDLE and data_out_valid drops next cycle.
REQ-019 Exactly one flag or none SHALL be set per result; flags SHALL be cleared on leaving DONE.

Reset
REQ-020 When rst_n=0 at a clock edge, SHALL enter IDLE, data_out_valid=0, data_out_0=0, all flags=0, quotient/remainder/counter=0; data_in_ready=1 in the first cycle after reset.
REQ-021 Reset in DIVIDE, NORM, or DONE SHALL abort the operation with no output produced.

Configuration
REQ-022 With FLOAT_DIV_RNE_EN defined, SHALL round to nearest-even: increment mant when guard & (sticky | mant[0]).
REQ-023 Without FLOAT_DIV_RNE_EN, SHALL truncate (guard/sticky ignored); latency unchanged.

Structure
REQ-024 Package float_div_pkg SHALL hold FP32_EXP_W=8, FP32_MANT_W=23, FP32_EXP_BIAS=127, QUOT_W=26, and the FSM state enum.
REQ-025 Normalise/round/exponent/flag logic of NORM SHALL be a combinational sub-module float_div_round; the iteration datapath stays in the top.

Verification
REQ-026 0x40C00000 / 0x40000000 (6/2) -> 0x40400000, no flags, data_out_valid 28 cycles after accept.
REQ-027 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with FLOAT_DIV_RNE_EN, 0x3EAAAAAA without.
REQ-028 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1, latency 1; 0x7F800000 / 0x3F800000 -> 0x00000000, exception=1.
REQ-029 0x7F000000 / 0x3E800000 -> 0x7F800000 overflow=1; 0x00800000 / 0x40000000 -> 0x00000000 underflow=1.
REQ-030 Hold data_out_ready=0 for 5 cycles in DONE -> output and flags stable, data_in_ready=0; release -> IDLE next cycle.
REQ-031 Assert rst_n=0 at DIVIDE cycle 10 -> IDLE, no data_out_valid; following 6/2 operation returns 0x40400000 correctly.
